// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Arbitrates the ideal memory's shared data port between the CPU
//            data interface and the host AXI-Lite interface. Each requester
//            has a valid/ready request channel and a registered one-cycle
//            response pulse. The CPU wins by default; a starvation limiter
//            forces a host grant after MAX_WAIT consecutive denials.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 11,
  parameter int MAX_WAIT   = 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  mips_cpu_clk,
  input  logic                  mips_cpu_resetn,
  input  logic                  cpu_req_valid,
  input  logic                  cpu_req_wr,
  input  logic [ADDR_WIDTH-3:0] cpu_req_addr,
  input  logic [31:0]           cpu_req_wdata,
  output logic                  cpu_req_ready,
  output logic                  cpu_resp_valid,
  output logic [31:0]           cpu_resp_data,
  input  logic                  host_req_valid,
  input  logic                  host_req_wr,
  input  logic [ADDR_WIDTH-3:0] host_req_addr,
  input  logic [31:0]           host_req_wdata,
  output logic                  host_req_ready,
  output logic                  host_resp_valid,
  output logic [31:0]           host_resp_data,
  output logic [ADDR_WIDTH-3:0] mem_raddr,
  output logic                  mem_rden,
  input  logic [31:0]           mem_rdata,
  output logic [ADDR_WIDTH-3:0] mem_waddr,
  output logic                  mem_wren,
  output logic [31:0]           mem_wdata,
  output logic [CNT_WIDTH-1:0]  contention_cnt
);

  // host_wait only has to count up to MAX_WAIT-1
  localparam int c_WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(MAX_WAIT - 1);

  typedef enum logic [0:0] {
    c_CPU_PRI  = 1'b0,
    c_HOST_PRI = 1'b1
  } state_t;

  state_t                r_state;
  logic [c_WAIT_W-1:0]   r_host_wait;
  logic                  r_cpu_resp_valid;
  logic [31:0]           r_cpu_resp_data;
  logic                  r_host_resp_valid;
  logic [31:0]           r_host_resp_data;
  logic [CNT_WIDTH-1:0]  r_contention_cnt;
  logic                  w_cpu_gnt;
  logic                  w_host_gnt;

  // Grants depend only on the valids and the priority state; reset masks both
  assign w_cpu_gnt  = mips_cpu_resetn && cpu_req_valid &&
                      ((r_state == c_CPU_PRI) || !host_req_valid);
  assign w_host_gnt = mips_cpu_resetn && host_req_valid &&
                      ((r_state == c_HOST_PRI) || !cpu_req_valid);

  assign cpu_req_ready  = w_cpu_gnt;
  assign host_req_ready = w_host_gnt;

  // A response still pending when reset is asserted is suppressed immediately
  assign cpu_resp_valid  = mips_cpu_resetn && r_cpu_resp_valid;
  assign cpu_resp_data   = mips_cpu_resetn ? r_cpu_resp_data : 32'h0;
  assign host_resp_valid = mips_cpu_resetn && r_host_resp_valid;
  assign host_resp_data  = mips_cpu_resetn ? r_host_resp_data : 32'h0;
  assign contention_cnt  = r_contention_cnt;

  // Drive the memory port from the granted requester in the transfer cycle only
  always_comb begin
    mem_rden  = 1'b0;
    mem_raddr = '0;
    mem_wren  = 1'b0;
    mem_waddr = '0;
    mem_wdata = 32'h0;
    if (w_cpu_gnt) begin
      if (cpu_req_wr) begin
        mem_wren  = 1'b1;
        mem_waddr = cpu_req_addr;
        mem_wdata = cpu_req_wdata;
      end else begin
        mem_rden  = 1'b1;
        mem_raddr = cpu_req_addr;
      end
    end else if (w_host_gnt) begin
      if (host_req_wr) begin
        mem_wren  = 1'b1;
        mem_waddr = host_req_addr;
        mem_wdata = host_req_wdata;
      end else begin
        mem_rden  = 1'b1;
        mem_raddr = host_req_addr;
      end
    end
  end

  // Register one-cycle response pulses; read data captured in the transfer cycle
  always_ff @(posedge mips_cpu_clk) begin
    if (!mips_cpu_resetn) begin
      r_cpu_resp_valid  <= 1'b0;
      r_cpu_resp_data   <= 32'h0;
      r_host_resp_valid <= 1'b0;
      r_host_resp_data  <= 32'h0;
    end else begin
      r_cpu_resp_valid  <= w_cpu_gnt;
      r_cpu_resp_data   <= (w_cpu_gnt && !cpu_req_wr) ? mem_rdata : 32'h0;
      r_host_resp_valid <= w_host_gnt;
      r_host_resp_data  <= (w_host_gnt && !host_req_wr) ? mem_rdata : 32'h0;
    end
  end

  // Priority FSM with starvation limiter for the host
  always_ff @(posedge mips_cpu_clk) begin
    if (!mips_cpu_resetn) begin
      r_state     <= c_CPU_PRI;
      r_host_wait <= '0;
    end else begin
      case (r_state)
        c_CPU_PRI: begin
          if (host_req_valid && !w_host_gnt) begin
            if (r_host_wait == c_WAIT_LAST) begin
              r_state     <= c_HOST_PRI;
              r_host_wait <= '0;
            end else begin
              r_host_wait <= r_host_wait + c_WAIT_W'(1);
            end
          end else begin
            r_host_wait <= '0;
          end
        end
        c_HOST_PRI: begin
          r_host_wait <= '0;
          if (w_host_gnt || !host_req_valid) begin
            r_state <= c_CPU_PRI;
          end
        end
        default: begin
          r_state     <= c_CPU_PRI;
          r_host_wait <= '0;
        end
      endcase
    end
  end

  // Saturating count of cycles in which both requesters are asking
  always_ff @(posedge mips_cpu_clk) begin
    if (!mips_cpu_resetn) begin
      r_contention_cnt <= '0;
    end else if (cpu_req_valid && host_req_valid && (r_contention_cnt != '1)) begin
      r_contention_cnt <= r_contention_cnt + CNT_WIDTH'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed scoreboard testbench for mem_port_arbiter with a
//            behavioural ideal memory attached to the shared port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int ADDR_WIDTH = 11;
  localparam int AW         = ADDR_WIDTH - 2;

  logic          mips_cpu_clk = 1'b0;
  logic          mips_cpu_resetn;
  logic          cpu_req_valid, cpu_req_wr;
  logic [AW-1:0] cpu_req_addr;
  logic [31:0]   cpu_req_wdata;
  logic          cpu_req_ready, cpu_resp_valid;
  logic [31:0]   cpu_resp_data;
  logic          host_req_valid, host_req_wr;
  logic [AW-1:0] host_req_addr;
  logic [31:0]   host_req_wdata;
  logic          host_req_ready, host_resp_valid;
  logic [31:0]   host_resp_data;
  logic [AW-1:0] mem_raddr, mem_waddr;
  logic          mem_rden, mem_wren;
  logic [31:0]   mem_rdata, mem_wdata;
  logic [31:0]   contention_cnt;

  mem_port_arbiter #(.ADDR_WIDTH(ADDR_WIDTH), .MAX_WAIT(8), .CNT_WIDTH(32)) dut (
    .mips_cpu_clk   (mips_cpu_clk),
    .mips_cpu_resetn(mips_cpu_resetn),
    .cpu_req_valid  (cpu_req_valid),
    .cpu_req_wr     (cpu_req_wr),
    .cpu_req_addr   (cpu_req_addr),
    .cpu_req_wdata  (cpu_req_wdata),
    .cpu_req_ready  (cpu_req_ready),
    .cpu_resp_valid (cpu_resp_valid),
    .cpu_resp_data  (cpu_resp_data),
    .host_req_valid (host_req_valid),
    .host_req_wr    (host_req_wr),
    .host_req_addr  (host_req_addr),
    .host_req_wdata (host_req_wdata),
    .host_req_ready (host_req_ready),
    .host_resp_valid(host_resp_valid),
    .host_resp_data (host_resp_data),
    .mem_raddr      (mem_raddr),
    .mem_rden       (mem_rden),
    .mem_rdata      (mem_rdata),
    .mem_waddr      (mem_waddr),
    .mem_wren       (mem_wren),
    .mem_wdata      (mem_wdata),
    .contention_cnt (contention_cnt)
  );

  always #5 mips_cpu_clk = ~mips_cpu_clk;

  // Ideal memory: combinational read, write on the rising edge
  logic [31:0] mem [0:(1<<AW)-1];
  assign mem_rdata = mem[mem_raddr];
  always @(posedge mips_cpu_clk) if (mem_wren) mem[mem_waddr] <= mem_wdata;

  int cyc = 0;
  always @(posedge mips_cpu_clk) cyc++;

  int total = 0;
  int bad   = 0;

  typedef struct { logic [31:0] d; int c; } exp_t;
  exp_t cpu_q[$];
  exp_t host_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every response pulse against the scoreboard queues
  always @(negedge mips_cpu_clk) begin
    exp_t e;
    check("ready_exclusive", {63'h0, cpu_req_ready && host_req_ready}, 64'h0);
    check("rden_wren_exclusive", {63'h0, mem_rden && mem_wren}, 64'h0);
    if (cpu_resp_valid) begin
      if (cpu_q.size() == 0) begin
        total++; bad++;
        $display("FAIL cpu_resp_unexpected: got data 0x%0h with no pending request (cycle %0d)", cpu_resp_data, cyc);
      end else begin
        e = cpu_q.pop_front();
        check("cpu_resp_data", {32'h0, cpu_resp_data}, {32'h0, e.d});
        check("cpu_resp_cycle", 64'(cyc), 64'(e.c));
      end
    end else if (cpu_q.size() > 0 && cpu_q[0].c <= cyc) begin
      e = cpu_q.pop_front();
      total++; bad++;
      $display("FAIL cpu_resp_missing: got no pulse, expected 0x%0h at cycle %0d", e.d, e.c);
    end
    if (host_resp_valid) begin
      if (host_q.size() == 0) begin
        total++; bad++;
        $display("FAIL host_resp_unexpected: got data 0x%0h with no pending request (cycle %0d)", host_resp_data, cyc);
      end else begin
        e = host_q.pop_front();
        check("host_resp_data", {32'h0, host_resp_data}, {32'h0, e.d});
        check("host_resp_cycle", 64'(cyc), 64'(e.c));
      end
    end else if (host_q.size() > 0 && host_q[0].c <= cyc) begin
      e = host_q.pop_front();
      total++; bad++;
      $display("FAIL host_resp_missing: got no pulse, expected 0x%0h at cycle %0d", e.d, e.c);
    end
  end

  // One request cycle: drive, check grant and memory drive mid-cycle, queue response
  task automatic step(input logic cv, input logic cw, input logic [AW-1:0] ca, input logic [31:0] cd,
                      input logic hv, input logic hw, input logic [AW-1:0] ha, input logic [31:0] hd,
                      input logic ecg, input logic ehg, input logic [31:0] cexp, input logic [31:0] hexp);
    cpu_req_valid = cv; cpu_req_wr = cw; cpu_req_addr = ca; cpu_req_wdata = cd;
    host_req_valid = hv; host_req_wr = hw; host_req_addr = ha; host_req_wdata = hd;
    @(negedge mips_cpu_clk);
    check("cpu_req_ready", {63'h0, cpu_req_ready}, {63'h0, ecg});
    check("host_req_ready", {63'h0, host_req_ready}, {63'h0, ehg});
    if (ecg) cpu_q.push_back('{cexp, cyc + 1});
    if (ehg) host_q.push_back('{hexp, cyc + 1});
    if (ecg || ehg) begin
      if ((ecg && cw) || (!ecg && hw)) begin
        check("mem_wr_drive", {mem_wren, mem_rden, 3'b0, mem_waddr, 19'h0, mem_wdata},
              {1'b1, 1'b0, 3'b0, (ecg ? ca : ha), 19'h0, (ecg ? cd : hd)});
      end else begin
        check("mem_rd_drive", {mem_wren, mem_rden, 3'b0, mem_raddr, 51'h0},
              {1'b0, 1'b1, 3'b0, (ecg ? ca : ha), 51'h0});
      end
    end else begin
      check("mem_idle", {62'h0, mem_rden, mem_wren}, 64'h0);
    end
    @(posedge mips_cpu_clk); #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, expected completion before 100000 time units");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] = 32'h0;
    mem[3] = 32'h12345678;
    mem[5] = 32'h11112222;

    // Reset with both requesters asking: no grants, no memory activity, no counting
    mips_cpu_resetn = 1'b0;
    cpu_req_valid = 1'b1; cpu_req_wr = 1'b0; cpu_req_addr = '0; cpu_req_wdata = '0;
    host_req_valid = 1'b1; host_req_wr = 1'b1; host_req_addr = '0; host_req_wdata = 32'hFFFF_FFFF;
    repeat (2) @(posedge mips_cpu_clk);
    #1;
    check("rst_ready", {62'h0, cpu_req_ready, host_req_ready}, 64'h0);
    check("rst_mem_en", {62'h0, mem_rden, mem_wren}, 64'h0);
    check("rst_contention", {32'h0, contention_cnt}, 64'h0);
    check("rst_resp", {62'h0, cpu_resp_valid, host_resp_valid}, 64'h0);
    check("rst_resp_data", {cpu_resp_data, host_resp_data}, 64'h0);
    mips_cpu_resetn = 1'b1;
    idle();

    // CPU-only write then read back
    step(1'b1, 1'b1, 9'h010, 32'hDEADBEEF, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'h0, '0);
    step(1'b1, 1'b0, 9'h010, 32'h0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'hDEADBEEF, '0);
    idle();

    // Host-only read of preloaded word
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 9'h003, '0, 1'b0, 1'b1, '0, 32'h12345678);
    idle();

    // Continuous contention: 8 CPU grants, forced host grant, then CPU again
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b0, 9'h010, '0, 1'b1, 1'b0, 9'h003, '0,
           (i != 9), (i == 9), 32'hDEADBEEF, 32'h12345678);
    end
    check("contention_10", {32'h0, contention_cnt}, 64'd10);
    idle();

    // Same address: CPU reads old data, host writes, CPU rereads new data
    step(1'b1, 1'b0, 9'h005, '0, 1'b1, 1'b1, 9'h005, 32'hA5A5A5A5, 1'b1, 1'b0, 32'h11112222, '0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 9'h005, 32'hA5A5A5A5, 1'b0, 1'b1, '0, 32'h0);
    step(1'b1, 1'b0, 9'h005, '0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'hA5A5A5A5, '0);
    idle();

    // Drive FSM into host priority, then reset right after a CPU read transfer
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0, 9'h010, '0, 1'b1, 1'b0, 9'h003, '0, 1'b1, 1'b0, 32'hDEADBEEF, '0);
    end
    void'(cpu_q.pop_back());
    mips_cpu_resetn = 1'b0;
    cpu_req_valid = 1'b0; host_req_valid = 1'b0;
    @(negedge mips_cpu_clk);
    check("rst_drop_resp", {62'h0, cpu_resp_valid, cpu_req_ready}, 64'h0);
    @(posedge mips_cpu_clk); #1;
    mips_cpu_resetn = 1'b1;
    check("rst_contention_clear", {32'h0, contention_cnt}, 64'h0);
    check("rst_resp_after", {63'h0, cpu_resp_valid}, 64'h0);
    // A surviving HOST_PRI state would grant the host here
    step(1'b1, 1'b0, 9'h010, '0, 1'b1, 1'b0, 9'h003, '0, 1'b1, 1'b0, 32'hDEADBEEF, '0);
    idle();

    // Host withdraws after 5 denials; wait counter must restart
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 1'b0, 9'h010, '0, 1'b1, 1'b0, 9'h003, '0, 1'b1, 1'b0, 32'hDEADBEEF, '0);
    end
    step(1'b1, 1'b0, 9'h010, '0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 32'hDEADBEEF, '0);
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b0, 9'h010, '0, 1'b1, 1'b0, 9'h003, '0,
           (i != 9), (i == 9), 32'hDEADBEEF, 32'h12345678);
    end
    check("contention_after_withdraw", {32'h0, contention_cnt}, 64'd16);
    repeat (3) idle();

    check("cpu_q_drained", 64'(cpu_q.size()), 64'h0);
    check("host_q_drained", 64'(host_q.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Cycle-level arbiter for the shared data port (read port 2 plus write port) of the ideal memory.
- Two requesters share the port: the MIPS CPU data interface and the host AXI-Lite interface.
- Replaces the static AND/OR muxing with a valid/ready request channel and a registered response channel per requester.
- CPU has default priority; a starvation limiter guarantees host progress.

Parameters:
- ADDR_WIDTH, 11, byte-address width of the ideal memory; word index is ADDR_WIDTH-2 bits.
- MAX_WAIT, 8, consecutive cycles a host request may be denied before the host gets priority (must be >=1).
- CNT_WIDTH, 32, width of the contention counter.

Ports:
- mips_cpu_clk, input, 1, single clock; all state updates on rising edge.
- mips_cpu_resetn, input, 1, synchronous, active-low reset.
- cpu_req_valid, input, 1, CPU request valid.
- cpu_req_wr, input, 1, 1=write, 0=read.
- cpu_req_addr, input, ADDR_WIDTH-2, word address.
- cpu_req_wdata, input, 32, write data.
- cpu_req_ready, output, 1, CPU request accepted this cycle.
- cpu_resp_valid, output, 1, one-cycle completion pulse.
- cpu_resp_data, output, 32, read data (0 for writes).
- host_req_valid / host_req_wr / host_req_addr / host_req_wdata, input, 1/1/ADDR_WIDTH-2/32, host request, same meaning as CPU.
- host_req_ready / host_resp_valid / host_resp_data, output, 1/1/32, host handshake, same meaning as CPU.
- mem_raddr, output, ADDR_WIDTH-2, memory read address.
- mem_rden, output, 1, memory read enable.
- mem_rdata, input, 32, memory read data; combinational from mem_raddr.
- mem_waddr, output, ADDR_WIDTH-2, memory write address.
- mem_wren, output, 1, memory write enable.
- mem_wdata, output, 32, memory write data.
- contention_cnt, output, CNT_WIDTH, number of cycles with both requests valid.

Behaviour:
- Reset (mips_cpu_resetn=0 at clock edge):
  - FSM -> CPU_PRI; host_wait=0; contention_cnt=0.
  - Both resp_valid=0; both resp_data=0.
  - A response pending at reset is dropped.
  - While resetn is low, both req_ready=0 and mem_rden=mem_wren=0 (combinationally gated).
- Handshake:
  - A request transfers in any cycle with valid&&ready.
  - A requester holds valid, wr, addr and wdata stable until ready. Dropping valid before ready is allowed and aborts the request.
  - ready is combinational from both valids and the FSM state. At most one ready is high per cycle.
- Memory drive, in the transfer cycle only:
  - Read: mem_rden=1, mem_raddr=addr.
  - Write: mem_wren=1, mem_waddr=addr, mem_wdata=wdata.
  - Otherwise all mem_* outputs are 0.
- Response:
  - Exactly 1 cycle after the transfer, resp_valid=1 for one cycle.
  - resp_data = mem_rdata registered in the transfer cycle for reads; 0 for writes.
  - There is no backpressure on the response. Back-to-back transfers produce back-to-back pulses.
- FSM CPU_PRI:
  - Grant CPU if cpu_req_valid, else grant host if host_req_valid.
  - If host_req_valid && !host granted: host_wait++.
  - When host_wait reaches MAX_WAIT-1 and the host is denied again, go to HOST_PRI next cycle.
  - host_wait clears on any host grant, or when host_req_valid=0.
- FSM HOST_PRI:
  - Grant host if host_req_valid, else grant CPU if cpu_req_valid.
  - After one host grant, or if host_req_valid=0, return to CPU_PRI; host_wait=0.
- contention_cnt: +1 every cycle with cpu_req_valid && host_req_valid (outside reset); saturates at all-ones.
- Read-after-write to the same address by different requesters in consecutive grants returns the new data (memory write at the edge, read combinational next cycle).

Test Plan:
- Reset, then CPU-only traffic: CPU write 0xDEADBEEF @0x10, then read @0x10 -> cpu_req_ready=1 both cycles; cpu_resp_valid pulses at T+1 and T+2; second resp_data=0xDEADBEEF; host_resp_valid stays 0.
- Host-only read @0x3 with memory preloaded 0x12345678 -> host_req_ready same cycle; host_resp_valid one cycle later with 0x12345678; mem_wren=0 throughout.
- Both valid continuously, MAX_WAIT=8:
  - CPU granted 8 cycles.
  - Host granted on cycle 9.
  - CPU granted on cycle 10.
  - contention_cnt=10 after 10 cycles.
- Simultaneous CPU read @0x5 and host write 0xA5A5A5A5 @0x5:
  - CPU gets old data first.
  - After the host write completes, a CPU reread returns 0xA5A5A5A5.
  - Never both mem_rden and mem_wren from different owners in one cycle.
- Assert resetn=0 the cycle after a CPU read transfer -> cpu_resp_valid stays 0, contention_cnt=0, FSM in CPU_PRI; first post-reset request is granted normally.
- Host valid withdrawn after 5 denied cycles, then reasserted -> host_wait restarts from 0; 8 further denials are needed before the host is forced through.
